// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: an A:Q:M datapath driven by a small
// IDLE/ITER/DONE controller, producing one quotient bit per clock.
module restoring_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         fin,
  output logic         div_by_zero,
  output logic         resta,
  output logic         desp
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [N-1:0]  ZERO_N   = {N{1'b0}};
  localparam logic [N-1:0]  ONES_N   = {N{1'b1}};
  localparam logic [N:0]    ZERO_A   = {(N+1){1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [N:0]     a_r;
  logic [N-1:0]   q_r;
  logic [N-1:0]   m_r;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   quotient_r;
  logic [N-1:0]   remainder_r;
  logic           div_by_zero_r;

  logic [N:0]     a_sh_s;
  logic [N:0]     trial_s;
  logic [N:0]     a_new_s;
  logic [N-1:0]   q_new_s;
  logic           zero_div_s;

  assign zero_div_s  = (divisor == ZERO_N);
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

  // Trial subtraction on the shifted partial remainder; a negative result
  // (sign bit of the N+1 bit trial) means the old value is restored.
  always_comb begin
    a_sh_s  = {a_r[N-1:0], q_r[N-1]};
    trial_s = a_sh_s - {1'b0, m_r};
    if (!trial_s[N]) begin
      a_new_s = trial_s;
      q_new_s = {q_r[N-2:0], 1'b1};
    end else begin
      a_new_s = a_sh_s;
      q_new_s = {q_r[N-2:0], 1'b0};
    end
  end

  // Controller next-state and per-cycle strobes.
  always_comb begin
    state_s = state_r;
    busy    = 1'b0;
    fin     = 1'b0;
    desp    = 1'b0;
    resta   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = zero_div_s ? DONE : ITER;
        end else begin
          state_s = IDLE;
        end
      end
      ITER: begin
        busy  = 1'b1;
        desp  = 1'b1;
        resta = ~trial_s[N];
        if (cnt_r == CNT_ZERO) begin
          state_s = DONE;
        end else begin
          state_s = ITER;
        end
      end
      DONE: begin
        fin     = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r           <= ZERO_A;
      q_r           <= ZERO_N;
      m_r           <= ZERO_N;
      cnt_r         <= CNT_ZERO;
      quotient_r    <= ZERO_N;
      remainder_r   <= ZERO_N;
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && zero_div_s) begin
            quotient_r    <= ONES_N;
            remainder_r   <= dividend;
            div_by_zero_r <= 1'b1;
          end else if (start) begin
            a_r           <= ZERO_A;
            q_r           <= dividend;
            m_r           <= divisor;
            cnt_r         <= CNT_LAST;
            div_by_zero_r <= 1'b0;
          end else begin
            a_r <= a_r;
          end
        end
        ITER: begin
          a_r <= a_new_s;
          q_r <= q_new_s;
          if (cnt_r == CNT_ZERO) begin
            quotient_r  <= q_new_s;
            remainder_r <= a_new_s[N-1:0];
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          a_r <= a_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed table, hand-written
// corner sequences, random operands and a full N=4 sweep against a model.
module tb_restoring_divider;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         fin;
  logic         div_by_zero;
  logic         resta;
  logic         desp;

  int errors = 0;
  int checks = 0;

  restoring_divider #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .fin        (fin),
    .div_by_zero(div_by_zero),
    .resta      (resta),
    .desp       (desp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  vec_t tbl[8];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge while the DUT is idle or in its fin cycle.
  // Reference: integer division; quotient bits appear MSB first as resta.
  task automatic op(input logic [N-1:0] dd, input logic [N-1:0] dv);
    logic [N-1:0] eq;
    logic [N-1:0] er;
    int           lat;
    eq  = (dv == 0) ? {N{1'b1}} : dd / dv;
    er  = (dv == 0) ? dd : dd % dv;
    lat = (dv == 0) ? 1 : N + 1;
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    if (fin) begin
      @(negedge clk);
      chk1("fin_cycle_start_ignored_busy", busy, 1'b0);
      chk1("fin_cycle_start_ignored_fin", fin, 1'b0);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    for (int c = 1; c < lat; c++) begin
      chk1("iter_busy", busy, 1'b1);
      chk1("iter_desp", desp, 1'b1);
      chk1("iter_resta", resta, eq[N-c]);
      chk1("iter_fin", fin, 1'b0);
      @(negedge clk);
    end
    chk1("done_fin", fin, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chk1("done_desp", desp, 1'b0);
    chk1("done_resta", resta, 1'b0);
    chkn("quotient", quotient, eq);
    chkn("remainder", remainder, er);
    chk1("div_by_zero", div_by_zero, (dv == 0) ? 1'b1 : 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chkn({tag, "_quotient"}, quotient, {N{1'b0}});
    chkn({tag, "_remainder"}, remainder, {N{1'b0}});
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_fin"}, fin, 1'b0);
    chk1({tag, "_dbz"}, div_by_zero, 1'b0);
    chk1({tag, "_resta"}, resta, 1'b0);
    chk1({tag, "_desp"}, desp, 1'b0);
  endtask

  initial begin
    tbl[0] = '{dd: 4'd13, dv: 4'd4, q: 4'd3,  r: 4'd1, dz: 1'b0};
    tbl[1] = '{dd: 4'd15, dv: 4'd1, q: 4'd15, r: 4'd0, dz: 1'b0};
    tbl[2] = '{dd: 4'd0,  dv: 4'd7, q: 4'd0,  r: 4'd0, dz: 1'b0};
    tbl[3] = '{dd: 4'd3,  dv: 4'd9, q: 4'd0,  r: 4'd3, dz: 1'b0};
    tbl[4] = '{dd: 4'd9,  dv: 4'd9, q: 4'd1,  r: 4'd0, dz: 1'b0};
    tbl[5] = '{dd: 4'd7,  dv: 4'd0, q: 4'd15, r: 4'd7, dz: 1'b1};
    tbl[6] = '{dd: 4'd8,  dv: 4'd2, q: 4'd4,  r: 4'd0, dz: 1'b0};
    tbl[7] = '{dd: 4'd14, dv: 4'd15, q: 4'd0, r: 4'd14, dz: 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      op(tbl[i].dd, tbl[i].dv);
      chkn("tbl_quotient", quotient, tbl[i].q);
      chkn("tbl_remainder", remainder, tbl[i].r);
      chk1("tbl_dbz", div_by_zero, tbl[i].dz);
      @(negedge clk);
    end

    // start during cycles 2 and 5 of a 13/4 operation is ignored.
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);                                  // cycle 1
    start = 1'b0;
    @(negedge clk);                                  // cycle 2
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(negedge clk);                                  // cycle 3
    start = 1'b0;
    chk1("ign_busy_c3", busy, 1'b1);
    @(negedge clk);                                  // cycle 4
    chk1("ign_resta_c4", resta, 1'b1);
    @(negedge clk);                                  // cycle 5
    chk1("ign_fin_c5", fin, 1'b1);
    chkn("ign_quotient", quotient, 4'd3);
    chkn("ign_remainder", remainder, 4'd1);
    start = 1'b1; dividend = 4'd15; divisor = 4'd0;
    @(negedge clk);                                  // cycle 6, idle
    start = 1'b0;
    chk1("ign_fin_c6", fin, 1'b0);
    chk1("ign_busy_c6", busy, 1'b0);
    chk1("ign_dbz_c6", div_by_zero, 1'b0);
    @(negedge clk);
    chk1("ign_busy_c7", busy, 1'b0);
    chk1("ign_fin_c7", fin, 1'b0);
    chkn("ign_quotient_held", quotient, 4'd3);
    chkn("ign_remainder_held", remainder, 4'd1);

    // Reset in cycle 2 aborts; a start in the reset cycle is ignored.
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);                                  // cycle 1
    start = 1'b0;
    @(negedge clk);                                  // cycle 2
    reset = 1'b1; start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk_all_zero("midreset");
    for (int c = 0; c < N + 2; c++) begin
      @(negedge clk);
      chk1("midreset_no_fin", fin, 1'b0);
      chk1("midreset_no_busy", busy, 1'b0);
    end
    op(4'd10, 4'd3);
    chkn("after_reset_q", quotient, 4'd3);
    chkn("after_reset_r", remainder, 4'd1);
    @(negedge clk);

    // Random operands, with random idle gaps or starts raised in the fin cycle.
    for (int k = 0; k < 40; k++) begin
      op(N'($urandom), N'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    if (fin) @(negedge clk);

    // Exhaustive sweep, back-to-back: each next start is raised in the fin cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op(N'(a), N'(b));
      end
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse-operation companion to the Booth multiplier unit in the same arithmetic datapath.
- It holds an internal control FSM and an A:Q:M datapath, and computes one quotient bit per clock.
- It exposes per-iteration strobes `resta` and `desp`, and a completion flag `fin`, with the same meaning the multiplier control uses. Shared observation logic and benches can therefore monitor both units.

Parameters:
- N, 4, operand width in bits for dividend, divisor, quotient and remainder; N >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- dividend  input  N  unsigned dividend; sampled on the edge that accepts start.
- divisor  input  N  unsigned divisor; sampled on the edge that accepts start.
- quotient  output  N  registered quotient; valid while fin=1 and held until next accepted start.
- remainder  output  N  registered remainder; same validity as quotient.
- busy  output  1  high while iterating.
- fin  output  1  one-cycle completion pulse.
- div_by_zero  output  1  set with fin when divisor==0; held until next accepted start.
- resta  output  1  high in an iteration cycle whose trial subtraction is kept (quotient bit 1).
- desp  output  1  high in every iteration cycle (shift performed).

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE.
  - A, Q, M and the counter are cleared.
  - quotient, remainder, busy, fin, div_by_zero, resta and desp are all 0.
- Reset mid-operation: abort at that edge, with no fin pulse and the state described above. A start asserted in the same cycle as reset is ignored.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - If start=1 and divisor!=0: load A=0 (N+1 bits, signed trial width), Q=dividend, M=divisor, cnt=N-1, and go to ITER.
  - If start=1 and divisor==0: go to DONE with quotient={N{1}}, remainder=dividend, div_by_zero=1. No iterations are performed.
  - Otherwise, stay in IDLE; outputs keep their previous results.
  - An accepted start clears div_by_zero, except in the divide-by-zero case.
- ITER (busy=1, desp=1), each edge:
  - Shift {A,Q} left by 1.
  - Compute T = A_shifted - {0,M} in N+1 bits.
  - If T[N]==0: A=T, Q[0]=1, and resta=1 in that cycle. Otherwise: A=A_shifted (restore), Q[0]=0, resta=0.
  - resta and desp are combinational from state and the current trial result, so they are valid during the cycle the edge commits.
  - If cnt==0, go to DONE and register quotient=Q_new, remainder=A_new[N-1:0]. Otherwise, decrement cnt.
- DONE: fin=1 for exactly one cycle, busy=0, then go to IDLE unconditionally.
- Latency: with start sampled at edge 0, ITER occupies cycles 1..N and fin is high in cycle N+1. For divide-by-zero, fin is high in cycle 1.
- start while in ITER or DONE is ignored (no queueing). The inputs dividend and divisor may change freely after the accepting edge.
- Back-to-back operation: start may be asserted in the fin cycle but is ignored there. It is accepted in the following IDLE cycle.
- Result invariant for divisor!=0: dividend == quotient*divisor + remainder, with remainder < divisor. All arithmetic is unsigned; there is no overflow case.
- resta, desp and busy are 0 outside ITER. fin is 0 outside DONE.

Test Plan:
- N=4, dividend=13, divisor=4, start one cycle -> busy high cycles 1..4, desp=1 in each, resta pattern 0,0,1,1 -> fin in cycle 5, quotient=3, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0, resta=1 all four iterations; dividend=0, divisor=7 -> quotient=0, remainder=0, resta never asserted.
- dividend=3, divisor=9 -> quotient=0, remainder=3; dividend=9, divisor=9 -> quotient=1, remainder=0.
- dividend=7, divisor=0 -> fin in cycle 1, div_by_zero=1, quotient=15, remainder=7, busy never high; then 8/2 -> div_by_zero cleared on accept, quotient=4, remainder=0.
- start=1 during cycles 2 and 5 of a 13/4 operation -> ignored, single fin, results unchanged; reset=1 in cycle 2 -> next cycle all outputs 0, state IDLE, no fin; subsequent 10/3 -> quotient=3, remainder=1.
- Exhaustive N=4 sweep of all 256 dividend/divisor pairs, back-to-back starts -> every result matches integer division and divide-by-zero rule; each op takes N+2 cycles start-to-next-accept.
